// File: rtl/uart_tx_if.sv
// Parallel-side bundle of the UART transmitter: request word, framing
// configuration, serial line and busy flag.
interface uart_tx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      TX_OUT;
    logic                      Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter: start, 8 data bits LSB first, optional parity, stop.
// Optional feature macro UART_TX_HOLD_BUF_EN adds a one-entry holding register.
module uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic    clk,
    input  logic    rst,
    uart_tx_if.slave tx
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic typ);
        return (^d) ^ typ;
    endfunction

    logic [2:0]                state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
    logic [2:0]                idx_q, idx_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      accept_s;
    logic                      bit_done_s;
    logic [PRESCALE_WIDTH-1:0] last_cnt_s;

`ifdef UART_TX_HOLD_BUF_EN
    logic                      hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0]     hold_data_q, hold_data_d;
    logic                      hold_par_en_q, hold_par_en_d;
    logic                      hold_par_typ_q, hold_par_typ_d;
    logic [PRESCALE_WIDTH-1:0] hold_pre_q, hold_pre_d;
`endif

    // Bit-period bookkeeping: a latched prescale of 0 behaves like 1.
    always_comb begin
        accept_s   = tx.Data_Valid & ~busy_q;
        last_cnt_s = (pre_q == {PRESCALE_WIDTH{1'b0}}) ? {PRESCALE_WIDTH{1'b0}}
                                                        : pre_q - {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
        bit_done_s = (cnt_q == last_cnt_s);
    end

    // Frame sequencing, request capture and holding-register management.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        pre_d     = pre_q;
`ifdef UART_TX_HOLD_BUF_EN
        hold_full_d    = hold_full_q;
        hold_data_d    = hold_data_q;
        hold_par_en_d  = hold_par_en_q;
        hold_par_typ_d = hold_par_typ_q;
        hold_pre_d     = hold_pre_q;
`endif
        if (state_q == ST_IDLE || bit_done_s) begin
            cnt_d = {PRESCALE_WIDTH{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
        end

        case (state_q)
            ST_IDLE: begin
                idx_d = 3'd0;
                if (accept_s) begin
                    state_d   = ST_START;
                    data_d    = tx.P_DATA;
                    par_en_d  = tx.PAR_EN;
                    par_typ_d = tx.PAR_TYP;
                    pre_d     = tx.Prescale;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_done_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
`ifdef UART_TX_HOLD_BUF_EN
                    if (hold_full_q) begin
                        state_d     = ST_START;
                        data_d      = hold_data_q;
                        par_en_d    = hold_par_en_q;
                        par_typ_d   = hold_par_typ_q;
                        pre_d       = hold_pre_q;
                        hold_full_d = 1'b0;
                    end else if (accept_s) begin
                        // A request landing on the final stop cycle chains directly.
                        state_d   = ST_START;
                        data_d    = tx.P_DATA;
                        par_en_d  = tx.PAR_EN;
                        par_typ_d = tx.PAR_TYP;
                        pre_d     = tx.Prescale;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef UART_TX_HOLD_BUF_EN
        if (accept_s && state_q != ST_IDLE && !(state_q == ST_STOP && bit_done_s)) begin
            hold_full_d    = 1'b1;
            hold_data_d    = tx.P_DATA;
            hold_par_en_d  = tx.PAR_EN;
            hold_par_typ_d = tx.PAR_TYP;
            hold_pre_d     = tx.Prescale;
        end else begin
            hold_full_d = hold_full_d;
        end
        busy_d = hold_full_d;
`else
        busy_d = (state_d != ST_IDLE);
`endif
    end

    // Serial line value for the state being entered, so TX_OUT is a flop output.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_d[idx_d];
            ST_PARITY: tx_d = parity_bit(data_d, par_typ_d);
            ST_IDLE:   tx_d = 1'b1;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {PRESCALE_WIDTH{1'b0}};
            pre_q     <= {PRESCALE_WIDTH{1'b0}};
            idx_q     <= 3'd0;
            data_q    <= {DATA_WIDTH{1'b0}};
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

`ifdef UART_TX_HOLD_BUF_EN
    // Holding register; reset discards any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_q    <= 1'b0;
            hold_data_q    <= {DATA_WIDTH{1'b0}};
            hold_par_en_q  <= 1'b0;
            hold_par_typ_q <= 1'b0;
            hold_pre_q     <= {PRESCALE_WIDTH{1'b0}};
        end else begin
            hold_full_q    <= hold_full_d;
            hold_data_q    <= hold_data_d;
            hold_par_en_q  <= hold_par_en_d;
            hold_par_typ_q <= hold_par_typ_d;
            hold_pre_q     <= hold_pre_d;
        end
    end
`endif

    assign tx.TX_OUT = tx_q;
    assign tx.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes expected frames, a line
// monitor decodes TX_OUT and compares. Honours UART_TX_HOLD_BUF_EN if defined.
module tb_uart_tx;

    typedef struct {
        logic [10:0] bits;
        int          nbits;
        int          p;
        logic [7:0]  data;
    } frame_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   last_gap;
    bit   mon_active;
    frame_t exp_q[$];

    uart_tx_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

    uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .tx  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference frame from the framing rules: bit list and cycles per bit.
    function automatic frame_t make_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                                          input logic [5:0] pre);
        frame_t f;
        f.data = d;
        f.p    = (pre == 6'd0) ? 1 : int'(pre);
        f.bits = 11'h7FF;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[i+1] = d[i];
        if (pen) begin
            f.bits[9]  = logic'(($countones(d) % 2 == 1) ^ (ptyp == 1'b1));
            f.bits[10] = 1'b1;
            f.nbits    = 11;
        end else begin
            f.bits[9] = 1'b1;
            f.nbits   = 10;
        end
        return f;
    endfunction

    // Line monitor: detects falling start edge, pops expected frame, compares every cycle.
    initial begin : monitor
        logic   prev;
        int     idx;
        int     errs;
        int     gap;
        frame_t f;
        prev = 1'b1; gap = 0; idx = 0; errs = 0; mon_active = 1'b0; last_gap = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0; prev = 1'b1; gap = 0;
            end else begin
                if (!mon_active) begin
                    if (prev && !bus.TX_OUT) begin
                        chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            f = exp_q.pop_front();
                            mon_active = 1'b1; idx = 0; errs = 0; last_gap = gap;
                        end
                    end else begin
                        gap++;
                    end
                end
                if (mon_active) begin
                    if (bus.TX_OUT !== f.bits[idx / f.p]) errs++;
                    idx++;
                    if (idx == f.nbits * f.p) begin
                        chk($sformatf("frame_%02h_p%0d_bits%0d_errcycles", f.data, f.p, f.nbits), errs, 0);
                        mon_active = 1'b0; gap = 0;
                    end
                end
                prev = bus.TX_OUT;
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || mon_active) && t < 3000) begin
            @(negedge clk); t++;
        end
        chk("drain_timeout", 32'(t < 3000), 32'd1);
    endtask

    // Issue one request at a negedge once Busy is low; returns one negedge later.
    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp, input logic [5:0] pre);
        int t = 0;
        while (bus.Busy && t < 3000) begin
            @(negedge clk); t++;
        end
        chk("busy_wait_timeout", 32'(t < 3000), 32'd1);
        bus.P_DATA = d; bus.PAR_EN = pen; bus.PAR_TYP = ptyp; bus.Prescale = pre;
        bus.Data_Valid = 1'b1;
        exp_q.push_back(make_frame(d, pen, ptyp, pre));
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        bus.P_DATA = 8'($urandom);
        bus.PAR_EN = 1'($urandom);
    endtask

    // Request plus start-bit latency and Busy duration checks.
    task automatic send_timed(input logic [7:0] d, input logic pen, input logic ptyp, input logic [5:0] pre);
        int cnt;
        int plen;
        plen = (pre == 6'd0) ? 1 : int'(pre);
        send(d, pen, ptyp, pre);
        chk($sformatf("start_bit_k1_%02h", d), 32'(bus.TX_OUT), 32'd0);
`ifndef UART_TX_HOLD_BUF_EN
        chk($sformatf("busy_k1_%02h", d), 32'(bus.Busy), 32'd1);
        cnt = 1;
        while (cnt < 2000) begin
            @(negedge clk);
            if (bus.Busy) cnt++;
            else break;
        end
        chk($sformatf("busy_len_%02h", d), cnt, (pen ? 11 : 10) * plen);
`else
        cnt = 0;
`endif
        wait_idle();
    endtask

    initial begin : stim
        int hi;
        n_checks = 0; n_pass = 0;
        rst = 1'b1;
        bus.P_DATA = 8'h00; bus.Data_Valid = 1'b0; bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0; bus.Prescale = 6'd8;
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(bus.TX_OUT), 32'd1);
        chk("reset_busy", 32'(bus.Busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send_timed(8'h45, 1'b0, 1'b0, 6'd8);
        send_timed(8'hAA, 1'b1, 1'b1, 6'd8);
        send_timed(8'hA8, 1'b1, 1'b0, 6'd8);
        send_timed(8'hFF, 1'b0, 1'b0, 6'd0);
        send_timed(8'hFF, 1'b0, 1'b0, 6'd1);
        send_timed(8'h00, 1'b1, 1'b1, 6'd1);

        // Prescale changes mid-frame must not affect the running frame.
        send(8'h3C, 1'b1, 1'b0, 6'd8);
        repeat (10) @(negedge clk);
        bus.Prescale = 6'd4;
        bus.PAR_TYP = 1'b1;
        wait_idle();

`ifndef UART_TX_HOLD_BUF_EN
        send(8'h81, 1'b0, 1'b0, 6'd4);
        repeat (4) @(negedge clk);
        chk("busy_at_drop", 32'(bus.Busy), 32'd1);
        bus.P_DATA = 8'h12; bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        wait_idle();
        repeat (50) @(negedge clk);
        chk("no_frame_after_drop", 32'(mon_active), 32'd0);
`else
        send(8'h55, 1'b0, 1'b0, 6'd4);
        repeat (2) @(negedge clk);
        chk("hold_free_mid_frame", 32'(bus.Busy), 32'd0);
        send(8'h0F, 1'b0, 1'b0, 6'd4);
        chk("hold_full_busy", 32'(bus.Busy), 32'd1);
        bus.P_DATA = 8'h99; bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        wait_idle();
        chk("b2b_gap", last_gap, 0);
        repeat (50) @(negedge clk);
        chk("no_frame_after_drop", 32'(mon_active), 32'd0);
`endif

        // Reset mid-frame aborts the frame and any pending word.
        send(8'h5A, 1'b1, 1'b0, 6'd8);
        repeat (10) @(negedge clk);
`ifdef UART_TX_HOLD_BUF_EN
        send(8'hC3, 1'b0, 1'b0, 6'd8);
`endif
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk("rst_mid_tx", 32'(bus.TX_OUT), 32'd1);
        chk("rst_mid_busy", 32'(bus.Busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.TX_OUT === 1'b1 && bus.Busy === 1'b0) hi++;
        end
        chk("line_high_after_rst", hi, 20);

        for (int n = 0; n < 24; n++) begin
            send(8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(0, 5)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART subsystem: accepts an 8-bit parallel word with a one-cycle valid strobe and drives the framed serial line (start bit, 8 data bits LSB first, optional parity, stop bit). Sits directly upstream of the UART receiver. Its TX_OUT feeds the receiver's RX_IN, using the same `Prescale`, `PAR_EN`, and `PAR_TYP` conventions, so the two blocks loop back bit-exactly.

## Interface
Parameters:
- `DATA_WIDTH`, 8: payload bits per frame; only 8 is supported.
- `PRESCALE_WIDTH`, 6: width of `Prescale`.

Ports:
- `clk`  input  1  single clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `P_DATA`  input  8  word to transmit; sampled on acceptance.
- `Data_Valid`  input  1  request strobe; accepted when `Busy`=0 in the same cycle.
- `PAR_EN`  input  1  1 = parity bit inserted after the data bits.
- `PAR_TYP`  input  1  selects the parity equation (see Operation).
- `Prescale`  input  6  clocks per serial bit; 0 is treated as 1.
- `TX_OUT`  output  1  serial line; idle high.
- `Busy`  output  1  1 = a `Data_Valid` in this cycle is not accepted.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Acceptance: `Data_Valid`=1 and `Busy`=0 at a rising edge. On acceptance, `P_DATA`, `PAR_EN`, `PAR_TYP`, and `Prescale` are latched together. Later input changes do not affect that frame.
- Bit timing: a 6-bit counter counts 0..P-1, where P = latched `Prescale`, or 1 if the latched value is 0. The FSM advances when the counter reaches P-1. The counter clears on every bit boundary.
- START drives 0 for P cycles, then enters DATA.
- DATA drives bits 0..7, LSB first, each for P cycles. A 3-bit index wraps 7→0 on exit.
  - Exit goes to PARITY if `PAR_EN`=1, otherwise to STOP.
- PARITY drives P cycles of:
  - `PAR_TYP`=0: XOR of the 8 data bits.
  - `PAR_TYP`=1: XNOR of the 8 data bits.
- STOP drives 1 for P cycles. It then returns to IDLE, or goes to START when a word is pending (see Configuration).
- `TX_OUT` is registered, with no combinational path from inputs.
- `Data_Valid` while `Busy`=1 is dropped silently: no error, no effect on the current frame.
- Reset mid-frame aborts the frame:
  - Next cycle: `TX_OUT`=1, `Busy`=0, state IDLE.
  - Any pending word is discarded.

## Timing
- Reset values: `TX_OUT`=1, `Busy`=0, state IDLE, counters 0, holding register empty.
- Acceptance at edge k:
  - `TX_OUT`=0 (start bit) from cycle k+1.
  - `Busy`=1 from cycle k+1.
- Frame length: 10·P cycles without parity, 11·P with parity.
- Without the macro:
  - `Busy` stays 1 through the last STOP cycle and is 0 in the first IDLE cycle.
  - The next acceptance is at the end of that IDLE cycle, so there is a minimum of one idle-high cycle between frames.
- Latency from acceptance edge to the first data bit: P+1 cycles.
- P=1: every state lasts exactly one cycle. A no-parity frame occupies cycles k+1..k+10.

## Configuration
- Macro: `UART_TX_HOLD_BUF_EN`.
- Defined:
  - Adds a one-entry holding register holding data plus latched config.
  - `Busy` means "holding register full".
  - While a frame is in progress and the register is empty, `Data_Valid` is accepted into the register.
  - On the last STOP cycle with the register full, the FSM goes directly to START: the next start bit begins the cycle after the stop bit, with zero idle gap.
  - The register empties on that transition, and `Busy` drops in the first START cycle.
  - Acceptance in IDLE with the register empty goes straight to START; the register is not used.
  - Simultaneous drain and new `Data_Valid` on the last STOP cycle: the request is not accepted, because `Busy` was 1 in that cycle.
- Undefined: no holding register, and `Busy` means "not IDLE".

## Test plan
- Reset: assert `rst` 2 cycles mid-frame with P=8 → next cycle `TX_OUT`=1, `Busy`=0. The line stays high for 20 cycles.
- No parity: P=8, `PAR_EN`=0, `P_DATA`=0x45 → line pattern 0,1,0,1,0,0,0,1,0,1 with each bit held 8 cycles; `Busy` high 80 cycles. Loopback into the receiver yields `P_DATA`=0x45 with `data_valid`.
- Parity:
  - P=8, `PAR_EN`=1, `PAR_TYP`=1, 0xAA → parity bit 1, 88-cycle frame.
  - `PAR_TYP`=0, 0xA8 → parity bit 1.
  - Loopback into the receiver yields 0xAA and 0xA8 respectively.
- Boundaries:
  - `Prescale`=0 and `Prescale`=1, data 0xFF → 10-cycle frames, identical to each other.
  - Change `Prescale` 8→4 mid-frame → current frame keeps 8 cycles per bit.
- Dropped request, without macro: `Data_Valid` with 0x12 at cycle k+5 during a frame → ignored, and only the first word appears on the line.
- Back-to-back, with macro: 0x55 then 0x0F issued 3 cycles apart, P=4 → the second start bit follows the first stop bit with zero gap. A third request while `Busy`=1 is dropped.
